// File: rtl/z88_pkg.sv
// ---------------------------------------------------------------------------
// z88_pkg
// Shared definitions for the Z88 LCD-to-VGA display back end:
//   - default 640x480@60 VGA timing values
//   - LCD geometry (320 columns, 64 rows, row field offset of 16)
//   - the four 12-bit {r,g,b} colours used on the raster
//   - the stage-1 sideband struct carried alongside the VRAM address
// ---------------------------------------------------------------------------
package z88_pkg;

  // VGA 640x480 @ 60 Hz, 25 MHz pixel clock
  localparam int DEF_H_ACT   = 640;
  localparam int DEF_H_FP    = 16;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BP    = 48;
  localparam int DEF_V_ACT   = 480;
  localparam int DEF_V_FP    = 10;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BP    = 33;
  localparam int DEF_WIN_TOP = 208;

  // LCD geometry. VRAM rows are stored with a +16 offset so that the
  // VGA line counter's low six bits address them directly when the band
  // starts on a line that is 16 mod 64.
  localparam int LCD_COLS    = 320;
  localparam int LCD_ROWS    = 64;
  localparam int LCD_ROW_OFS = 16;

  // Colours as {r,g,b}, 4 bits each
  localparam logic [11:0] COL_BLANK    = 12'h000;
  localparam logic [11:0] COL_PIX_OFF  = 12'hAC9;
  localparam logic [11:0] COL_PIX_ON   = 12'h232;
  localparam logic [11:0] COL_PIX_GRAY = 12'h685;

  // Sideband that travels with the VRAM address through stage 1
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic win;
    logic hLsb;
  } stage1_t;

  localparam stage1_t STAGE1_RST = '{hs: 1'b1, vs: 1'b1, de: 1'b0,
                                     win: 1'b0, hLsb: 1'b0};

endpackage

// File: rtl/z88_vga_if.sv
// ---------------------------------------------------------------------------
// z88_vga_if
// Bundles the VRAM read port and the VGA DAC pins of the display back end.
//   vram_addr  : 15-bit read address {col[8:0], row[5:0]}
//   vram_data  : 3-bit read data {gray, pixL, pixR}, valid one clk later
//   vga_r/g/b  : 4-bit colour
//   vga_hs/vs  : syncs, active low
//   vga_de     : active-video flag
// Modports:
//   master : the display back end (drives address and pins)
//   slave  : VRAM read port / board side (drives read data)
// ---------------------------------------------------------------------------
interface z88_vga_if;

  logic [14:0] vram_addr;
  logic [2:0]  vram_data;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;

  modport master (
    output vram_addr,
    input  vram_data,
    output vga_r,
    output vga_g,
    output vga_b,
    output vga_hs,
    output vga_vs,
    output vga_de
  );

  modport slave (
    input  vram_addr,
    output vram_data,
    input  vga_r,
    input  vga_g,
    input  vga_b,
    input  vga_hs,
    input  vga_vs,
    input  vga_de
  );

endinterface

// File: rtl/z88_vga_timing.sv
// ---------------------------------------------------------------------------
// z88_vga_timing
// Horizontal/vertical raster counters and raw (unregistered) decode of the
// sync, display-enable and LCD-window flags. Counters advance only on
// pix_ena_i, so all state holds while the pixel tick stalls.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   pix_ena_i    : one-clk-wide pixel tick
//   h_ctr_o      : horizontal position, 0 .. H_TOT-1
//   v_ctr_o      : vertical position, 0 .. V_TOT-1
//   hs_o, vs_o   : raw syncs, active low
//   de_o         : raw active-video flag
//   win_o        : raw LCD-band flag (subset of de_o)
// ---------------------------------------------------------------------------
module z88_vga_timing
  import z88_pkg::*;
#(
  parameter int H_ACT   = DEF_H_ACT,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_ACT   = DEF_V_ACT,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP,
  parameter int WIN_TOP = DEF_WIN_TOP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ena_i,
  output logic [9:0] h_ctr_o,
  output logic [9:0] v_ctr_o,
  output logic       hs_o,
  output logic       vs_o,
  output logic       de_o,
  output logic       win_o
);

  localparam logic [9:0] H_LAST   = 10'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACT + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACT + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACT + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_ACT_W  = 10'(H_ACT);
  localparam logic [9:0] V_ACT_W  = 10'(V_ACT);
  localparam logic [9:0] WIN_LO   = 10'(WIN_TOP);
  localparam logic [9:0] WIN_HI   = 10'(WIN_TOP + LCD_ROWS - 1);

  logic [9:0] hCtr_q, hCtr_d;
  logic [9:0] vCtr_q, vCtr_d;

  // The line counter steps once per horizontal wrap.
  always_comb begin
    hCtr_d = hCtr_q;
    vCtr_d = vCtr_q;
    if (pix_ena_i) begin
      if (hCtr_q == H_LAST) begin
        hCtr_d = '0;
        vCtr_d = (vCtr_q == V_LAST) ? '0 : vCtr_q + 10'd1;
      end else begin
        hCtr_d = hCtr_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hCtr_q <= '0;
      vCtr_q <= '0;
    end else begin
      hCtr_q <= hCtr_d;
      vCtr_q <= vCtr_d;
    end
  end

  always_comb begin
    hs_o  = !((hCtr_q >= HS_FIRST) && (hCtr_q <= HS_LAST));
    vs_o  = !((vCtr_q >= VS_FIRST) && (vCtr_q <= VS_LAST));
    de_o  = (hCtr_q < H_ACT_W) && (vCtr_q < V_ACT_W);
    win_o = de_o && (vCtr_q >= WIN_LO) && (vCtr_q <= WIN_HI);
  end

  assign h_ctr_o = hCtr_q;
  assign v_ctr_o = vCtr_q;

endmodule

// File: rtl/z88_vga.sv
// ---------------------------------------------------------------------------
// z88_vga
// Display back end for the Z88 LCD emulation. Scans the 320x64 LCD VRAM and
// produces a 640x480@60 VGA raster with the LCD rows shown as a centred
// band, and toggles new_fr_tgl once per frame at the start of vertical
// blanking so the screen stage can render the next LCD frame.
//
// Two pixel-tick pipeline stages:
//   stage 1 : register VRAM address plus hs/vs/de/win/h_ctr[0]
//   stage 2 : sample VRAM data, register colour and hs/vs/de
// Outputs therefore lag the raster counters by exactly two pix_ena ticks.
//
// Ports:
//   clk, rst_n  : 50 MHz clock, asynchronous active-low reset
//   pix_ena     : 25 MHz pixel tick, one clk wide
//   new_fr_tgl  : inverts once per frame
//   vif         : z88_vga_if.master (VRAM read port + VGA pins)
//
// Configuration macro: Z88_VGA_GRAY_EN
//   defined   -> on-pixels with the gray attribute render COL_PIX_GRAY
//   undefined -> gray bit ignored, every on-pixel renders COL_PIX_ON
// ---------------------------------------------------------------------------
module z88_vga
  import z88_pkg::*;
#(
  parameter int H_ACT   = DEF_H_ACT,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_ACT   = DEF_V_ACT,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP,
  parameter int WIN_TOP = DEF_WIN_TOP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ena,
  output logic       new_fr_tgl,
  z88_vga_if.master  vif
);

  localparam logic [9:0] V_ACT_W = 10'(V_ACT);

  logic [9:0] hCtr;
  logic [9:0] vCtr;
  logic       hsRaw;
  logic       vsRaw;
  logic       deRaw;
  logic       winRaw;

  z88_vga_timing #(
    .H_ACT   (H_ACT),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACT   (V_ACT),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .WIN_TOP (WIN_TOP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_ena_i (pix_ena),
    .h_ctr_o   (hCtr),
    .v_ctr_o   (vCtr),
    .hs_o      (hsRaw),
    .vs_o      (vsRaw),
    .de_o      (deRaw),
    .win_o     (winRaw)
  );

  // -------------------------------------------------------------------------
  // Stage 1: VRAM address and sideband
  // -------------------------------------------------------------------------
  stage1_t     s1_q, s1_d;
  logic [14:0] vramAddr_q, vramAddr_d;

  // Each VRAM word holds two horizontally adjacent VGA pixels, hence the
  // column comes from h_ctr[9:1]. The row field is v_ctr[5:0] directly
  // because VRAM rows already carry the +16 offset.
  always_comb begin
    s1_d       = '{hs: hsRaw, vs: vsRaw, de: deRaw, win: winRaw,
                   hLsb: hCtr[0]};
    vramAddr_d = winRaw ? {hCtr[9:1], vCtr[5:0]} : 15'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= STAGE1_RST;
      vramAddr_q <= '0;
    end else if (pix_ena) begin
      s1_q       <= s1_d;
      vramAddr_q <= vramAddr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: colour and delayed syncs
  // -------------------------------------------------------------------------
  logic        grayBit;
  logic        pixOn;
  logic [11:0] colour_q, colour_d;
  logic        hs_q, vs_q, de_q;

`ifdef Z88_VGA_GRAY_EN
  assign grayBit = vif.vram_data[2];
`else
  logic unusedGray;
  assign unusedGray = vif.vram_data[2];
  assign grayBit    = 1'b0;
`endif

  // win is only ever set inside de, so anything outside the band
  // (including blanking) falls through to black.
  always_comb begin
    pixOn = s1_q.hLsb ? vif.vram_data[0] : vif.vram_data[1];
    if (!s1_q.win) begin
      colour_d = COL_BLANK;
    end else if (!pixOn) begin
      colour_d = COL_PIX_OFF;
    end else if (grayBit) begin
      colour_d = COL_PIX_GRAY;
    end else begin
      colour_d = COL_PIX_ON;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colour_q <= COL_BLANK;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      de_q     <= 1'b0;
    end else if (pix_ena) begin
      colour_q <= colour_d;
      hs_q     <= s1_q.hs;
      vs_q     <= s1_q.vs;
      de_q     <= s1_q.de;
    end
  end

  // -------------------------------------------------------------------------
  // Frame toggle: fires on the tick where the raster sits at the first pixel
  // of vertical blanking. The counters reset to (0,0), so reset itself can
  // never look like a frame start.
  // -------------------------------------------------------------------------
  logic tgl_q, tgl_d;
  logic frameStart;

  always_comb begin
    frameStart = (hCtr == 10'd0) && (vCtr == V_ACT_W);
    tgl_d      = tgl_q ^ frameStart;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgl_q <= 1'b0;
    end else if (pix_ena) begin
      tgl_q <= tgl_d;
    end
  end

  assign new_fr_tgl    = tgl_q;
  assign vif.vram_addr = vramAddr_q;
  assign vif.vga_r     = colour_q[11:8];
  assign vif.vga_g     = colour_q[7:4];
  assign vif.vga_b     = colour_q[3:0];
  assign vif.vga_hs    = hs_q;
  assign vif.vga_vs    = vs_q;
  assign vif.vga_de    = de_q;

endmodule

// File: tb/tb_z88_vga.sv
// ---------------------------------------------------------------------------
// tb_z88_vga
// Two instances: dutFull at the default 640x480 timing, used for the line
// timing literals right after reset, and dutSmall with a shrunken raster
// (48 x 87 ticks, LCD band at lines 16..79) so whole frames fit in a short
// run. dutSmall is compared every clk against a position-based reference.
// pix_ena is randomised with stalls; a mid-frame reset is applied once.
// ---------------------------------------------------------------------------
module tb_z88_vga;

  localparam int S_HA = 32, S_HF = 4, S_HS = 8, S_HB = 4;
  localparam int S_VA = 80, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_WT = 16;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

`ifdef Z88_VGA_GRAY_EN
  localparam bit GRAY_EN = 1'b1;
`else
  localparam bit GRAY_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_ena = 1'b0;
  logic tglSmall;
  logic tglFull;

  z88_vga_if smallIf ();
  z88_vga_if fullIf ();

  z88_vga #(
    .H_ACT(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACT(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .WIN_TOP(S_WT)
  ) dutSmall (
    .clk(clk), .rst_n(rst_n), .pix_ena(pix_ena),
    .new_fr_tgl(tglSmall), .vif(smallIf)
  );

  z88_vga dutFull (
    .clk(clk), .rst_n(rst_n), .pix_ena(pix_ena),
    .new_fr_tgl(tglFull), .vif(fullIf)
  );

  always #10 clk = ~clk;

  // VRAM model: registered read, data valid one clk after the address
  logic [2:0] vram [0:32767];
  always @(posedge clk) begin
    smallIf.vram_data <= vram[smallIf.vram_addr];
    fullIf.vram_data  <= vram[fullIf.vram_addr];
  end

  int total = 0;
  int bad = 0;
  bit running = 1'b1;
  int ticks = 0;
  bit tglExp = 1'b0;
  logic tglPrev = 1'b0;
  int tglAt[$];

  bit   fullActive = 1'b0;
  bit   fullDone = 1'b0;
  logic fullHsPrev = 1'b1;
  int   fall1 = -1, fall2 = -1, rise1 = -1, deCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Expected {hs, vs, de, rgb} for the raster position of tick index idx
  function automatic logic [14:0] modelOut(input int idx);
    int h, v, addr;
    logic hs, vs, de, win, pix;
    logic [2:0]  w;
    logic [11:0] rgb;
    if (idx < 0) return {1'b1, 1'b1, 1'b0, 12'h000};
    h   = idx % S_HT;
    v   = (idx / S_HT) % S_VT;
    hs  = !(h >= S_HA + S_HF && h < S_HA + S_HF + S_HS);
    vs  = !(v >= S_VA + S_VF && v < S_VA + S_VF + S_VS);
    de  = (h < S_HA) && (v < S_VA);
    win = de && (v >= S_WT) && (v < S_WT + 64);
    rgb = 12'h000;
    if (win) begin
      addr = (h / 2) * 64 + (v % 64);
      w    = vram[addr];
      pix  = (h % 2 == 0) ? w[1] : w[0];
      if (!pix) rgb = 12'hAC9;
      else if (w[2] && GRAY_EN) rgb = 12'h685;
      else rgb = 12'h232;
    end
    return {hs, vs, de, rgb};
  endfunction

  function automatic logic [14:0] modelAddr(input int idx);
    int h, v;
    if (idx < 0) return 15'd0;
    h = idx % S_HT;
    v = (idx / S_HT) % S_VT;
    if (h < S_HA && v >= S_WT && v < S_WT + 64) return 15'((h / 2) * 64 + (v % 64));
    return 15'd0;
  endfunction

  // pix_ena: random ticks, never on two consecutive clks
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pix_ena) pix_ena = 1'b0;
      else pix_ena = running && ($urandom_range(0, 3) != 0);
    end
  end

  // Compare process: model update and full comparison on every clk
  initial begin
    logic sEna, sRst;
    logic [14:0] e;
    int idx, h, v;
    forever begin
      @(posedge clk);
      sEna = pix_ena;
      sRst = rst_n;
      #2;
      if (!sRst) begin
        ticks = 0;
        tglExp = 1'b0;
        tglPrev = 1'b0;
        tglAt.delete();
      end else if (sEna) begin
        ticks++;
        idx = ticks - 1;
        if (idx % S_HT == 0 && (idx / S_HT) % S_VT == S_VA) tglExp = ~tglExp;
      end
      e = modelOut(ticks - 2);
      checkOutput("hs", smallIf.vga_hs, e[14]);
      checkOutput("vs", smallIf.vga_vs, e[13]);
      checkOutput("de", smallIf.vga_de, e[12]);
      checkOutput("rgb", {smallIf.vga_r, smallIf.vga_g, smallIf.vga_b}, e[11:0]);
      checkOutput("addr", smallIf.vram_addr, modelAddr(ticks - 1));
      checkOutput("tgl", tglSmall, tglExp);
      if (tglSmall !== tglPrev) tglAt.push_back(ticks);
      tglPrev = tglSmall;

      if (sRst && sEna && ticks >= 2) begin
        idx = ticks - 2;
        h = idx % S_HT;
        v = (idx / S_HT) % S_VT;
        if (v == 16 && h == 10)
          checkOutput("win_l16_p10", {smallIf.vga_r, smallIf.vga_g, smallIf.vga_b}, 12'h232);
        if (v == 16 && h == 11)
          checkOutput("win_l16_p11", {smallIf.vga_r, smallIf.vga_g, smallIf.vga_b}, 12'hAC9);
        if (v == 15 && h == 10)
          checkOutput("win_l15_p10", {smallIf.vga_r, smallIf.vga_g, smallIf.vga_b}, 12'h000);
        if (v == 17 && h < 2)
          checkOutput("gray_l17", {smallIf.vga_r, smallIf.vga_g, smallIf.vga_b},
                      GRAY_EN ? 12'h685 : 12'h232);
      end

      if (fullActive && sRst && sEna) begin
        if (fullHsPrev === 1'b1 && fullIf.vga_hs === 1'b0) begin
          if (fall1 < 0) fall1 = ticks;
          else if (fall2 < 0) fall2 = ticks;
        end
        if (fullHsPrev === 1'b0 && fullIf.vga_hs === 1'b1 && rise1 < 0) rise1 = ticks;
        if (fall1 >= 0 && fall2 < 0 && fullIf.vga_de === 1'b1) deCnt++;
        fullHsPrev = fullIf.vga_hs;
        if (ticks == 1500 && !fullDone) begin
          fullDone = 1'b1;
          checkOutput("full_first_hs_fall", fall1, 658);
          checkOutput("full_hs_low", rise1 - fall1, 96);
          checkOutput("full_hs_period", fall2 - fall1, 800);
          checkOutput("full_de_per_line", deCnt, 640);
        end
      end
    end
  end

  // Run until the model has seen `target` ticks, with a clk budget
  task automatic applyStimulus(input int target);
    int guard;
    guard = 0;
    while (ticks < target && guard < target * 8 + 100) begin
      @(posedge clk);
      guard++;
    end
    if (ticks < target) begin
      total++;
      bad++;
      $display("[TB] FAIL tick_budget: got %0d expected %0d", ticks, target);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) vram[i] = 3'($urandom_range(0, 7));
    vram[5 * 64 + 16] = 3'b010;
    vram[0 * 64 + 17] = 3'b111;

    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #5;
    checkOutput("rst_full_hs", fullIf.vga_hs, 1);
    checkOutput("rst_full_vs", fullIf.vga_vs, 1);
    checkOutput("rst_full_de", fullIf.vga_de, 0);
    checkOutput("rst_full_rgb", {fullIf.vga_r, fullIf.vga_g, fullIf.vga_b}, 0);
    checkOutput("rst_full_addr", fullIf.vram_addr, 0);
    checkOutput("rst_full_tgl", tglFull, 0);
    rst_n = 1'b1;
    fullActive = 1'b1;

    // Mid-frame reset at small-raster line 50, pixel 20
    applyStimulus(50 * S_HT + 21);
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    fullActive = 1'b0;
    repeat (3) @(posedge clk);
    #5;
    checkOutput("midrst_tgl", tglSmall, 0);
    checkOutput("midrst_hs", smallIf.vga_hs, 1);
    checkOutput("midrst_addr", smallIf.vram_addr, 0);
    rst_n = 1'b1;

    // Two frame starts, then a little more
    applyStimulus(S_HT * S_VA + 1 + S_HT * S_VT + 500);
    checkOutput("tgl_count", tglAt.size(), 2);
    if (tglAt.size() == 2) begin
      checkOutput("tgl_first_tick", tglAt[0], S_HT * S_VA + 1);
      checkOutput("tgl_interval", tglAt[1] - tglAt[0], S_HT * S_VT);
    end

    running = 1'b0;
    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
